// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle control sequencer.
package ctrl_pkg;

    // Opcodes outside the R-type (00xxxx) and immediate (01xxxx) classes
    localparam logic [5:0] OP_LW   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100001;
    localparam logic [5:0] OP_BEQ  = 6'b100010;
    localparam logic [5:0] OP_BNE  = 6'b100011;
    localparam logic [5:0] OP_CALL = 6'b100100;
    localparam logic [5:0] OP_RET  = 6'b100101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [4:0] ALU_ADD = 5'h00;
    localparam logic [4:0] ALU_SUB = 5'h01;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt,
        StTrap
    } state_e;

    typedef enum logic [2:0] {
        CauseNone       = 3'd0,
        CauseIllegal    = 3'd1,
        CauseRetUnder   = 3'd2,
        CauseCallOver   = 3'd3,
        CauseMemTimeout = 3'd4
    } cause_e;

    // One-hot instruction class produced by ctrl_decode
    typedef struct packed {
        logic alu;
        logic imm;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic call;
        logic ret;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. master = sequencer, slave = datapath side.
interface multicycle_ctrl_if;
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ack;

    logic        RegDst;
    logic        ALUSrc;
    logic        Mem2Reg;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        PCSrc;
    logic        push;
    logic        pop;
    logic [4:0]  ALUOp;
    logic        pc_we;
    logic        mem_req;
    logic        halted;
    logic        trap;
    logic [2:0]  trap_cause;
    logic [31:0] instr_count;

    modport master (
        input  run, op, zero, mem_ack,
        output RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc, push, pop,
        output ALUOp, pc_we, mem_req, halted, trap, trap_cause, instr_count
    );

    modport slave (
        output run, op, zero, mem_ack,
        input  RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc, push, pop,
        input  ALUOp, pc_we, mem_req, halted, trap, trap_cause, instr_count
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> instruction class and ALU function.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output op_class_t  cls_o,
    output logic [4:0] alu_op_o
);

    // Classify opcode and pick the ALU function for its EXEC step
    always_comb begin
        cls_o    = '0;
        alu_op_o = ALU_ADD;
        case (op_i[5:4])
            2'b00: begin
                cls_o.alu = 1'b1;
                alu_op_o  = {1'b0, op_i[3:0]};
            end
            2'b01: begin
                cls_o.imm = 1'b1;
                alu_op_o  = {1'b0, op_i[3:0]};
            end
            default: begin
                case (op_i)
                    OP_LW:   cls_o.lw   = 1'b1;
                    OP_SW:   cls_o.sw   = 1'b1;
                    OP_BEQ:  begin cls_o.beq = 1'b1; alu_op_o = ALU_SUB; end
                    OP_BNE:  begin cls_o.bne = 1'b1; alu_op_o = ALU_SUB; end
                    OP_CALL: cls_o.call = 1'b1;
                    OP_RET:  cls_o.ret  = 1'b1;
                    OP_HALT: cls_o.halt = 1'b1;
                    default: cls_o.illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) with call-depth and trap tracking.
// Optional memory-wait watchdog enabled by defining CTRL_MEM_TIMEOUT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input logic                clk,
    input logic                reset,
    multicycle_ctrl_if.master  bus
);

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic        depth_q, depth_d;
    cause_e      cause_q, cause_d;
    logic [31:0] count_q, count_d;

    op_class_t   cls;
    logic [4:0]  alu_op;
    logic [5:0]  dec_op;
    logic        timeout;
    state_e      st_end;

    logic regdst, alusrc, mem2reg, memread, memwrite, regwrite, pcsrc, push, pop, pc_we;
    logic [4:0] aluop;

    // DECODE routes on the live opcode (op_q is only written at its end); later states use op_q
    assign dec_op = (state_q == StDecode) ? bus.op : op_q;

    ctrl_decode u_decode (
        .op_i     (dec_op),
        .cls_o    (cls),
        .alu_op_o (alu_op)
    );

    assign st_end = bus.run ? StFetch : StIdle;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WaitLast = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] wait_q, wait_d;

    // Watchdog: held at zero outside MEM, counts MEM cycles without an ack
    always_comb begin
        wait_d = wait_q;
        if (state_q != StMem) begin
            wait_d = '0;
        end else if (!bus.mem_ack) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Fires on the cycle the counter would reach all-ones
    assign timeout = (state_q == StMem) && !bus.mem_ack && (wait_q == WaitLast);
`else
    assign timeout = 1'b0;
`endif

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            depth_q <= 1'b0;
            cause_q <= CauseNone;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            depth_q <= depth_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Next-state, opcode latch, call depth, trap cause and retire counter
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        depth_d = depth_q;
        cause_d = cause_q;
        count_d = pc_we ? count_q + 32'd1 : count_q;
        unique case (state_q)
            StIdle:   if (bus.run) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                op_d = bus.op;
                if (cls.illegal) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else if (cls.ret && !depth_q) begin
                    state_d = StTrap;
                    cause_d = CauseRetUnder;
                end else if (cls.call && depth_q) begin
                    state_d = StTrap;
                    cause_d = CauseCallOver;
                end else if (cls.halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cls.alu || cls.imm) begin
                    state_d = StWb;
                end else if (cls.lw || cls.sw) begin
                    state_d = StMem;
                end else begin
                    state_d = st_end;
                end
                if (cls.call) depth_d = 1'b1;
                if (cls.ret)  depth_d = 1'b0;
            end
            StMem: begin
                if (bus.mem_ack) begin
                    state_d = cls.lw ? StWb : st_end;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = CauseMemTimeout;
                end
            end
            StWb:    state_d = st_end;
            StHalt:  state_d = StHalt;
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    // Moore control decode; only PCSrc (zero) and pc_we in MEM (mem_ack) see inputs directly
    always_comb begin
        regdst   = 1'b0;
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        pcsrc    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        pc_we    = 1'b0;
        aluop    = ALU_ADD;
        unique case (state_q)
            StExec, StWb: begin
                if (cls.alu || cls.imm) begin
                    aluop    = alu_op;
                    regdst   = cls.alu;
                    alusrc   = cls.imm;
                    regwrite = (state_q == StWb);
                    pc_we    = (state_q == StWb);
                end else if (cls.lw && state_q == StWb) begin
                    memread  = 1'b1;
                    mem2reg  = 1'b1;
                    regwrite = 1'b1;
                    pc_we    = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    aluop  = ALU_ADD;
                    alusrc = 1'b1;
                end else if (cls.beq || cls.bne) begin
                    aluop = alu_op;
                    pcsrc = cls.beq ? bus.zero : ~bus.zero;
                    pc_we = 1'b1;
                end else if (cls.call) begin
                    push  = 1'b1;
                    pcsrc = 1'b1;
                    pc_we = 1'b1;
                end else if (cls.ret) begin
                    pop   = 1'b1;
                    pc_we = 1'b1;
                end
            end
            StMem: begin
                memread  = cls.lw;
                memwrite = cls.sw;
                pc_we    = cls.sw && bus.mem_ack;
            end
            default: ;
        endcase
    end

    assign bus.RegDst      = regdst;
    assign bus.ALUSrc      = alusrc;
    assign bus.Mem2Reg     = mem2reg;
    assign bus.MemRead     = memread;
    assign bus.MemWrite    = memwrite;
    assign bus.RegWrite    = regwrite;
    assign bus.PCSrc       = pcsrc;
    assign bus.push        = push;
    assign bus.pop         = pop;
    assign bus.ALUOp       = aluop;
    assign bus.pc_we       = pc_we;
    assign bus.mem_req     = memread | memwrite;
    assign bus.halted      = (state_q == StHalt);
    assign bus.trap        = (state_q == StTrap);
    assign bus.trap_cause  = cause_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; expectations are hand-derived per instruction step.
module tb_multicycle_ctrl;

    // Control vector order: {RegDst,ALUSrc,Mem2Reg,MemRead,MemWrite,RegWrite,PCSrc,push,pop,pc_we,mem_req}
    localparam logic [10:0] K_RD   = 11'h400;
    localparam logic [10:0] K_AS   = 11'h200;
    localparam logic [10:0] K_M2R  = 11'h100;
    localparam logic [10:0] K_MR   = 11'h080;
    localparam logic [10:0] K_MW   = 11'h040;
    localparam logic [10:0] K_RW   = 11'h020;
    localparam logic [10:0] K_PCS  = 11'h010;
    localparam logic [10:0] K_PUSH = 11'h008;
    localparam logic [10:0] K_POP  = 11'h004;
    localparam logic [10:0] K_PCWE = 11'h002;
    localparam logic [10:0] K_MREQ = 11'h001;

    // Status vector order: {halted, trap, trap_cause[2:0]}
    localparam logic [4:0] S_OK   = 5'b00000;
    localparam logic [4:0] S_HALT = 5'b10000;

    localparam logic [5:0] OP_LW   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100001;
    localparam logic [5:0] OP_BEQ  = 6'b100010;
    localparam logic [5:0] OP_BNE  = 6'b100011;
    localparam logic [5:0] OP_CALL = 6'b100100;
    localparam logic [5:0] OP_RET  = 6'b100101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [10:0] ctl;
    logic [4:0]  stat;
    assign ctl  = {bus.RegDst, bus.ALUSrc, bus.Mem2Reg, bus.MemRead, bus.MemWrite, bus.RegWrite,
                   bus.PCSrc, bus.push, bus.pop, bus.pc_we, bus.mem_req};
    assign stat = {bus.halted, bus.trap, bus.trap_cause};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag, input logic [10:0] c, input logic [4:0] a,
                         input logic [4:0] s);
        chk({tag, " ctl"}, 32'(ctl), 32'(c));
        chk({tag, " aluop"}, 32'(bus.ALUOp), 32'(a));
        chk({tag, " status"}, 32'(stat), 32'(s));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.run = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0; bus.op = '0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("reset", 11'h0, 5'h0, S_OK);
        chk("reset count", bus.instr_count, 32'd0);

        // R-type op 000010: FETCH, DECODE, EXEC, WB
        reset = 1'b0; bus.run = 1'b1; bus.op = 6'b000010;
        tick(); check("alu fetch", 11'h0, 5'h0, S_OK);
        tick(); check("alu decode", 11'h0, 5'h0, S_OK);
        tick(); check("alu exec", K_RD, 5'h02, S_OK);
        bus.op = 6'b101010;                     // op_q must be the latched copy
        tick(); check("alu wb", K_RD | K_RW | K_PCWE, 5'h02, S_OK);
        chk("alu count before", bus.instr_count, 32'd0);
        bus.run = 1'b0;
        tick(); check("alu idle", 11'h0, 5'h0, S_OK);
        chk("alu count", bus.instr_count, 32'd1);

        // Immediate op then back-to-back LW with ack on 4th MEM cycle
        bus.run = 1'b1; bus.op = 6'b010101;
        tick(); tick();
        tick(); check("imm exec", K_AS, 5'h05, S_OK);
        tick(); check("imm wb", K_AS | K_RW | K_PCWE, 5'h05, S_OK);
        bus.op = OP_LW;
        tick(); check("lw fetch", 11'h0, 5'h0, S_OK);
        tick();
        tick(); check("lw exec", K_AS, 5'h00, S_OK);
        bus.mem_ack = 1'b1;                     // stray ack outside MEM
        tick(); bus.mem_ack = 1'b0;
        check("lw mem1", K_MR | K_MREQ, 5'h0, S_OK);
        tick(); check("lw mem2", K_MR | K_MREQ, 5'h0, S_OK);
        tick(); check("lw mem3", K_MR | K_MREQ, 5'h0, S_OK);
        tick(); bus.mem_ack = 1'b1; #1;
        check("lw mem4 ack", K_MR | K_MREQ, 5'h0, S_OK);
        bus.run = 1'b0;
        tick(); bus.mem_ack = 1'b0;
        check("lw wb", K_MR | K_M2R | K_RW | K_PCWE | K_MREQ, 5'h0, S_OK);
        chk("lw count before", bus.instr_count, 32'd2);
        tick(); check("lw idle", 11'h0, 5'h0, S_OK);
        chk("lw count", bus.instr_count, 32'd3);

        // BEQ taken, BEQ not taken, BNE taken
        bus.run = 1'b1; bus.op = OP_BEQ; bus.zero = 1'b1;
        tick(); tick();
        tick(); check("beq z1", K_PCS | K_PCWE, 5'h01, S_OK);
        bus.zero = 1'b0;
        tick(); tick();
        tick(); check("beq z0", K_PCWE, 5'h01, S_OK);
        bus.op = OP_BNE;
        tick(); tick();
        tick(); check("bne z0", K_PCS | K_PCWE, 5'h01, S_OK);
        chk("branch count before", bus.instr_count, 32'd5);
        bus.run = 1'b0;
        tick(); chk("branch count", bus.instr_count, 32'd6);

        // RET with empty call register
        do_reset();
        check("reset2", 11'h0, 5'h0, S_OK);
        chk("reset2 count", bus.instr_count, 32'd0);
        bus.run = 1'b1; bus.op = OP_RET;
        tick(); tick();
        tick(); check("ret underflow", 11'h0, 5'h0, 5'b01010);
        tick(); check("ret underflow hold", 11'h0, 5'h0, 5'b01010);

        // CALL, CALL -> overflow
        do_reset();
        bus.run = 1'b1; bus.op = OP_CALL;
        tick(); tick();
        tick(); check("call1", K_PUSH | K_PCS | K_PCWE, 5'h0, S_OK);
        tick(); tick();
        tick(); check("call overflow", 11'h0, 5'h0, 5'b01011);
        chk("call count", bus.instr_count, 32'd1);

        // CALL, RET, RET -> second RET underflows
        do_reset();
        bus.run = 1'b1; bus.op = OP_CALL;
        tick(); tick(); tick();
        bus.op = OP_RET;
        tick(); tick();
        tick(); check("ret pop", K_POP | K_PCWE, 5'h0, S_OK);
        tick(); tick();
        tick(); check("ret2 underflow", 11'h0, 5'h0, 5'b01010);
        chk("call-ret count", bus.instr_count, 32'd2);

        // Reset during LW MEM
        do_reset();
        bus.run = 1'b1; bus.op = 6'b010001;
        tick(); tick(); tick(); tick();
        bus.op = OP_LW;
        tick(); tick(); tick();
        tick(); check("lw mem pre-reset", K_MR | K_MREQ, 5'h0, S_OK);
        chk("pre-reset count", bus.instr_count, 32'd1);
        reset = 1'b1;
        tick(); check("reset in mem", 11'h0, 5'h0, S_OK);
        chk("reset in mem count", bus.instr_count, 32'd0);
        reset = 1'b0; bus.run = 1'b0;
        tick(); check("idle after reset", 11'h0, 5'h0, S_OK);

        // Illegal opcode
        bus.run = 1'b1; bus.op = 6'b101010;
        tick(); tick();
        tick(); check("illegal", 11'h0, 5'h0, 5'b01001);

        // HALT
        do_reset();
        bus.run = 1'b1; bus.op = OP_HALT;
        tick(); tick();
        tick(); check("halt", 11'h0, 5'h0, S_HALT);
        tick(); check("halt hold", 11'h0, 5'h0, S_HALT);
        chk("halt count", bus.instr_count, 32'd0);

        // SW without ack
        do_reset();
        bus.run = 1'b1; bus.op = OP_SW;
        tick(); tick();
        tick(); check("sw exec", K_AS, 5'h0, S_OK);
        tick(); check("sw mem1", K_MW | K_MREQ, 5'h0, S_OK);
        bus.run = 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
        repeat (254) tick();
        check("sw mem255", K_MW | K_MREQ, 5'h0, S_OK);
        tick(); check("sw timeout", 11'h0, 5'h0, 5'b01100);
        chk("sw timeout count", bus.instr_count, 32'd0);
`else
        repeat (300) tick();
        check("sw mem wait", K_MW | K_MREQ, 5'h0, S_OK);
        bus.mem_ack = 1'b1; #1;
        check("sw ack", K_MW | K_MREQ | K_PCWE, 5'h0, S_OK);
        tick(); bus.mem_ack = 1'b0;
        check("sw idle", 11'h0, 5'h0, S_OK);
        chk("sw count", bus.instr_count, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
